// File: rtl/insight_trace_capture.sv
// Hart-0 trace trigger/capture: arms on request, starts at a programmed PC,
// buffers commit/exception records in a circular FIFO and drains them on a valid/ready stream.
module insight_trace_capture #(
  parameter int DEPTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             cfg_arm,
  input  logic             cfg_abort,
  input  logic [31:0]      cfg_start_pc,
  input  logic [CNT_W-1:0] cfg_stop_count,
  input  logic             commit,
  input  logic [31:0]      pc,
  input  logic [31:0]      instruction,
  input  logic             exception,
  input  logic             interrupt_fire,
  input  logic [2:0]       mode,
  input  logic             rd_wenx,
  input  logic [4:0]       rd_waddr,
  input  logic [31:0]      rd_wdata,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_pc,
  output logic [31:0]      out_instruction,
  output logic [31:0]      out_rd_wdata,
  output logic [4:0]       out_rd_waddr,
  output logic [6:0]       out_flags,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] captured_count,
  output logic [CNT_W-1:0] dropped_count,
  output logic             done
);
  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ARMED   = 2'd1,
    S_CAPTURE = 2'd2,
    S_DRAIN   = 2'd3
  } state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] wdata;
    logic [4:0]  waddr;
    logic [6:0]  flags;
  } rec_t;

  state_e                  state_q, state_d;
  logic [31:0]             start_pc_q, start_pc_d;
  logic [CNT_W-1:0]        stop_cnt_q, stop_cnt_d;
  logic [CNT_W-1:0]        cap_cnt_q, cap_cnt_d;
  logic [CNT_W-1:0]        drop_cnt_q, drop_cnt_d;
  logic                    gap_q, gap_d;
  logic                    done_q, done_d;
  rec_t [DEPTH-1:0]        mem_q, mem_d;
  logic [AW:0]             wr_ptr_q, wr_ptr_d;
  logic [AW:0]             rd_ptr_q, rd_ptr_d;

  logic empty, full, pop, push, evt, take_evt;
  rec_t rec_in, head;

  // Extra pointer MSB distinguishes full from empty when the low bits match.
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign pop   = !empty && out_ready;
  assign evt   = commit || exception || interrupt_fire;

  always_comb begin
    rec_in       = '0;
    rec_in.pc    = pc;
    rec_in.instr = instruction;
    rec_in.wdata = rd_wenx ? rd_wdata : 32'd0;
    rec_in.waddr = rd_wenx ? rd_waddr : 5'd0;
    rec_in.flags = {gap_q, exception, interrupt_fire, rd_wenx, mode};
  end

  always_comb begin
    state_d    = state_q;
    start_pc_d = start_pc_q;
    stop_cnt_d = stop_cnt_q;
    cap_cnt_d  = cap_cnt_q;
    drop_cnt_d = drop_cnt_q;
    gap_d      = gap_q;
    done_d     = 1'b0;
    take_evt   = 1'b0;
    push       = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (cfg_arm && !cfg_abort) begin
          state_d    = S_ARMED;
          start_pc_d = cfg_start_pc;
          stop_cnt_d = cfg_stop_count;
          cap_cnt_d  = '0;
          drop_cnt_d = '0;
          gap_d      = 1'b0;
        end
      end
      S_ARMED: begin
        if (cfg_abort) begin
          state_d = S_IDLE;
        end else if (evt && pc == start_pc_q) begin
          state_d  = S_CAPTURE;
          take_evt = 1'b1;
        end
      end
      S_CAPTURE: begin
        if (cfg_abort) state_d = S_DRAIN;
        else           take_evt = evt;
      end
      S_DRAIN: begin
        if (empty) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // A full FIFO still accepts when its head leaves on the same edge.
    if (take_evt) begin
      if (!full || pop) begin
        push      = 1'b1;
        gap_d     = 1'b0;
        cap_cnt_d = (&cap_cnt_q) ? cap_cnt_q : cap_cnt_q + 1'b1;
        if (stop_cnt_q != '0 && cap_cnt_d == stop_cnt_q) state_d = S_DRAIN;
      end else begin
        gap_d      = 1'b1;
        drop_cnt_d = (&drop_cnt_q) ? drop_cnt_q : drop_cnt_q + 1'b1;
      end
    end
  end

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) begin
      mem_d[wr_ptr_q[AW-1:0]] = rec_in;
      wr_ptr_d                = wr_ptr_q + 1'b1;
    end
    if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      start_pc_q <= '0;
      stop_cnt_q <= '0;
      cap_cnt_q  <= '0;
      drop_cnt_q <= '0;
      gap_q      <= 1'b0;
      done_q     <= 1'b0;
      mem_q      <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
    end else begin
      state_q    <= state_d;
      start_pc_q <= start_pc_d;
      stop_cnt_q <= stop_cnt_d;
      cap_cnt_q  <= cap_cnt_d;
      drop_cnt_q <= drop_cnt_d;
      gap_q      <= gap_d;
      done_q     <= done_d;
      mem_q      <= mem_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
    end
  end

  // Stale entries behind the read pointer are masked so an empty FIFO reads all zeros.
  assign head            = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];
  assign out_valid       = !empty;
  assign out_pc          = head.pc;
  assign out_instruction = head.instr;
  assign out_rd_wdata    = head.wdata;
  assign out_rd_waddr    = head.waddr;
  assign out_flags       = head.flags;
  assign state           = state_q;
  assign captured_count  = cap_cnt_q;
  assign dropped_count   = drop_cnt_q;
  assign done            = done_q;

endmodule

// File: tb/tb_insight_trace_capture.sv
// Directed bench for insight_trace_capture: expected records are queued as events are
// driven and compared against each record the DUT hands over on the output stream.
module tb_insight_trace_capture;
  localparam int DEPTH = 8;
  localparam int CNT_W = 16;

  logic             clock, reset_n;
  logic             cfg_arm, cfg_abort;
  logic [31:0]      cfg_start_pc;
  logic [CNT_W-1:0] cfg_stop_count;
  logic             commit, exception, interrupt_fire, rd_wenx;
  logic [31:0]      pc, instruction, rd_wdata;
  logic [2:0]       mode;
  logic [4:0]       rd_waddr;
  logic             out_valid, out_ready;
  logic [31:0]      out_pc, out_instruction, out_rd_wdata;
  logic [4:0]       out_rd_waddr;
  logic [6:0]       out_flags;
  logic [1:0]       state;
  logic [CNT_W-1:0] captured_count, dropped_count;
  logic             done;

  int vectors     = 0;
  int miscompares = 0;
  int done_cnt    = 0;
  logic [107:0] exp_q[$];

  insight_trace_capture #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clock(clock), .reset_n(reset_n),
    .cfg_arm(cfg_arm), .cfg_abort(cfg_abort),
    .cfg_start_pc(cfg_start_pc), .cfg_stop_count(cfg_stop_count),
    .commit(commit), .pc(pc), .instruction(instruction),
    .exception(exception), .interrupt_fire(interrupt_fire), .mode(mode),
    .rd_wenx(rd_wenx), .rd_waddr(rd_waddr), .rd_wdata(rd_wdata),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_instruction(out_instruction),
    .out_rd_wdata(out_rd_wdata), .out_rd_waddr(out_rd_waddr), .out_flags(out_flags),
    .state(state), .captured_count(captured_count), .dropped_count(dropped_count),
    .done(done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #400000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Monitor: each handshake seen mid-cycle is the pop at the next rising edge.
  always @(negedge clock) begin
    if (reset_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) chk("sb_unexpected_record", {96'd0, out_pc}, 128'd0);
      else chk("record", {out_pc, out_instruction, out_rd_wdata, out_rd_waddr, out_flags},
               exp_q.pop_front());
    end
    if (done) done_cnt++;
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic arm(input logic [31:0] spc, input logic [CNT_W-1:0] stop);
    cfg_arm = 1'b1; cfg_start_pc = spc; cfg_stop_count = stop;
    step();
    cfg_arm = 1'b0; cfg_start_pc = 32'hFFFF_FFFF; cfg_stop_count = '1;
  endtask

  // One trace cycle; when cap is set the bench-predicted record joins the scoreboard.
  task automatic ev(input logic [31:0] p, input logic c, input logic e, input logic i,
                    input logic [2:0] m, input logic w, input logic [4:0] a,
                    input logic [31:0] d, input logic cap, input logic g);
    pc = p; instruction = p ^ 32'h1357_9BDF; commit = c; exception = e;
    interrupt_fire = i; mode = m; rd_wenx = w; rd_waddr = a; rd_wdata = d;
    if (cap) exp_q.push_back({p, p ^ 32'h1357_9BDF, w ? d : 32'd0, w ? a : 5'd0,
                              g, e, i, w, m});
    step();
    commit = 1'b0; exception = 1'b0; interrupt_fire = 1'b0;
  endtask

  task automatic cev(input logic [31:0] p, input logic cap, input logic g);
    ev(p, 1'b1, 1'b0, 1'b0, 3'b011, 1'b1, p[6:2], ~p, cap, g);
  endtask

  task automatic wait_idle(input string tag);
    for (int k = 0; k < 64 && state != 2'd0; k++) step();
    chk(tag, state, 2'd0);
    step();
  endtask

  initial begin
    reset_n = 1'b0; cfg_arm = 1'b0; cfg_abort = 1'b0; cfg_start_pc = '0; cfg_stop_count = '0;
    commit = 1'b0; pc = '0; instruction = '0; exception = 1'b0; interrupt_fire = 1'b0;
    mode = '0; rd_wenx = 1'b0; rd_waddr = '0; rd_wdata = '0; out_ready = 1'b0;
    step(); step();
    chk("rst_state", state, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_out", {out_pc, out_instruction, out_rd_wdata, out_rd_waddr, out_flags}, 0);
    chk("rst_counts", {captured_count, dropped_count}, 0);
    chk("rst_done", done, 0);
    reset_n = 1'b1;
    step();

    // Trigger at 0x..10 with stop_count 3.
    out_ready = 1'b1; done_cnt = 0;
    arm(32'h8000_0010, 16'd3);
    chk("trig_armed", state, 2'd1);
    cev(32'h8000_0008, 0, 0);
    cev(32'h8000_000C, 0, 0);
    cev(32'h8000_0010, 1, 0);
    chk("trig_capture", state, 2'd2);
    cev(32'h8000_0014, 1, 0);
    cev(32'h8000_0018, 1, 0);
    chk("trig_drain", state, 2'd3);
    cev(32'h8000_001C, 0, 0);
    wait_idle("trig_idle");
    chk("trig_captured", captured_count, 16'd3);
    chk("trig_done_cnt", done_cnt, 1);
    chk("trig_sb_empty", exp_q.size(), 0);

    // Overflow with a stalled consumer, then full FIFO with simultaneous pop.
    out_ready = 1'b0; done_cnt = 0;
    arm(32'h0000_1000, 16'd0);
    for (int n = 0; n < 11; n++) cev(32'h0000_1000 + 32'(4 * n), n < DEPTH, 0);
    chk("ovf_captured", captured_count, 16'd8);
    chk("ovf_dropped", dropped_count, 16'd3);
    chk("ovf_state", state, 2'd2);
    out_ready = 1'b1;
    cev(32'h0000_1100, 1, 1);
    out_ready = 1'b0;
    chk("fullpop_captured", captured_count, 16'd9);
    chk("fullpop_dropped", dropped_count, 16'd3);
    cev(32'h0000_1104, 0, 0);
    chk("fullpop_still_full", dropped_count, 16'd4);
    out_ready = 1'b1;
    for (int k = 0; k < 64 && out_valid; k++) step();
    chk("ovf_drained", out_valid, 0);
    cev(32'h0000_1200, 1, 1);
    cev(32'h0000_1204, 1, 0);
    cfg_abort = 1'b1; step(); cfg_abort = 1'b0;
    chk("ovf_abort_drain", state, 2'd3);
    wait_idle("ovf_idle");
    chk("ovf_final_counts", {captured_count, dropped_count}, {16'd11, 16'd4});
    chk("ovf_done_cnt", done_cnt, 1);
    chk("ovf_sb_empty", exp_q.size(), 0);

    // Trap record and rd_wenx=0 masking.
    done_cnt = 0;
    arm(32'h0000_2000, 16'd2);
    ev(32'h0000_2000, 0, 0, 0, 3'b011, 1, 5'd5, 32'h1111, 0, 0);
    chk("trap_not_event", state, 2'd1);
    ev(32'h0000_2000, 0, 1, 0, 3'b011, 1, 5'd5, 32'h1111, 1, 0);
    ev(32'h0000_2004, 1, 0, 1, 3'b100, 0, 5'd7, 32'hDEAD, 1, 0);
    wait_idle("trap_idle");
    chk("trap_captured", captured_count, 16'd2);
    chk("trap_done_cnt", done_cnt, 1);
    chk("trap_sb_empty", exp_q.size(), 0);

    // Abort racing the trigger while ARMED.
    done_cnt = 0;
    arm(32'h0000_3000, 16'd0);
    cfg_abort = 1'b1;
    cev(32'h0000_3000, 0, 0);
    cfg_abort = 1'b0;
    chk("race_state", state, 2'd0);
    chk("race_captured", captured_count, 0);
    step(); step();
    chk("race_valid", out_valid, 0);
    chk("race_no_done", done_cnt, 0);

    // Abort in CAPTURE with two records queued; the racing event is lost.
    out_ready = 1'b0;
    arm(32'h0000_3100, 16'd0);
    cev(32'h0000_3100, 1, 0);
    cev(32'h0000_3104, 1, 0);
    cfg_abort = 1'b1;
    cev(32'h0000_3108, 0, 0);
    cfg_abort = 1'b0;
    chk("abort_drain", state, 2'd3);
    chk("abort_captured", captured_count, 16'd2);
    out_ready = 1'b1;
    wait_idle("abort_idle");
    chk("abort_done_cnt", done_cnt, 1);
    chk("abort_sb_empty", exp_q.size(), 0);

    // Asynchronous reset mid-DRAIN with five records queued.
    out_ready = 1'b0;
    arm(32'h0000_4000, 16'd5);
    for (int n = 0; n < 5; n++) cev(32'h0000_4000 + 32'(4 * n), 1, 0);
    chk("rst2_drain", state, 2'd3);
    #2 reset_n = 1'b0;
    #1;
    chk("rst2_valid", out_valid, 0);
    chk("rst2_state", state, 0);
    chk("rst2_counts", {captured_count, dropped_count}, 0);
    chk("rst2_out", {out_pc, out_flags}, 0);
    exp_q.delete();
    step();
    reset_n = 1'b1;
    step();
    out_ready = 1'b1; done_cnt = 0;
    arm(32'h0000_5000, 16'd1);
    chk("rst2_rearm", state, 2'd1);
    cev(32'h0000_5000, 1, 0);
    wait_idle("rst2_idle");
    chk("rst2_captured", captured_count, 16'd1);
    chk("rst2_done_cnt", done_cnt, 1);
    chk("rst2_sb_empty", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/insight_trace_capture.md
# insight_trace_capture

Trigger-and-capture controller for the hart-0 core monitor trace. Watches the per-cycle commit/exception trace from the core. Arms on a software request and starts capturing at a programmed PC. Buffers up to DEPTH trace records in an internal FIFO and drains them over a valid/ready stream to the Insight logger/serializer. Also counts captured and dropped records for status readback.

## Interface
Parameters:
- DEPTH, 8, FIFO entries; power of two, minimum 2
- CNT_W, 16, width of the stop-count field and the status counters

Ports:
- clock  in  1  sole clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- cfg_arm  in  1  single-cycle pulse; arms the capture
- cfg_abort  in  1  single-cycle pulse; terminates arming or capture
- cfg_start_pc  in  32  trigger PC; latched on an accepted cfg_arm
- cfg_stop_count  in  CNT_W  records to capture; 0 means unlimited; latched on an accepted cfg_arm
- commit  in  1  instruction retired this cycle
- pc  in  32  PC of the instruction
- instruction  in  32  instruction word
- exception  in  1  exception at this instruction
- interrupt_fire  in  1  interrupt taken at this instruction
- mode  in  3  {debug, priv[1:0]}
- rd_wenx  in  1  integer rd write enable
- rd_waddr  in  5  rd number
- rd_wdata  in  32  rd write data
- out_valid  out  1  head record available
- out_ready  in  1  consumer accepts the head record
- out_pc  out  32  head record PC
- out_instruction  out  32  head record instruction
- out_rd_wdata  out  32  head record rd data; 0 when rd_wenx was low
- out_rd_waddr  out  5  head record rd number; 0 when rd_wenx was low
- out_flags  out  7  {gap, exception, interrupt_fire, rd_wenx, mode[2:0]}
- state  out  2  0 IDLE, 1 ARMED, 2 CAPTURE, 3 DRAIN
- captured_count  out  CNT_W  records pushed since the last arm; saturating
- dropped_count  out  CNT_W  records lost to a full FIFO since the last arm; saturating
- done  out  1  one-cycle pulse on the DRAIN→IDLE transition

## Operation
- Trace event: cycle with commit | exception | interrupt_fire. Faulting, non-retired instructions are therefore recorded.
- IDLE:
  - cfg_arm with cfg_abort low → ARMED.
  - On that transition: latch cfg_start_pc and cfg_stop_count, clear both counters, clear the internal gap flag.
- ARMED:
  - Event with pc == latched start PC → CAPTURE. The triggering event itself is captured.
  - Events before the trigger are ignored. They are not counted as dropped.
- CAPTURE, on every event:
  - Push when the FIFO is not full, or is full with a pop in the same cycle: captured_count+1.
  - Otherwise drop: dropped_count+1 and set gap.
  - The next pushed record carries flags.gap=1. Gap then clears.
  - When latched stop_count ≠ 0 and the post-push captured_count == stop_count → DRAIN in the same edge.
- DRAIN:
  - No pushes.
  - FIFO empty → IDLE with done=1 for one cycle. If the FIFO is already empty on entry, exit after exactly one cycle in DRAIN.
- cfg_abort:
  - Has priority over cfg_arm and over an event in the same cycle; that event is not captured.
  - ARMED → IDLE, with no done pulse.
  - CAPTURE → DRAIN.
  - Ignored in IDLE and DRAIN.
- cfg_arm outside IDLE is ignored, and so are its cfg values.
- Counters saturate at all-ones and never wrap.
- FIFO:
  - Pointer-based circular buffer with wrap-around.
  - Pop when out_valid & out_ready.
  - out_valid = !empty. out_* are driven from the head entry.
  - The FIFO keeps draining in every state. Records left over from an aborted capture stay poppable after return to IDLE until consumed. Arming does not flush.

## Timing
- Reset values: state=IDLE, out_valid=0, out_pc/out_instruction/out_rd_wdata=0, out_rd_waddr=0, out_flags=0, captured_count=0, dropped_count=0, done=0. FIFO is empty and gap is cleared.
- Reset mid-capture discards the FIFO contents and all latched configuration.
- Latency:
  - Event at edge N → record visible on out_* with out_valid=1 after edge N, if the FIFO was empty.
  - No combinational path from trace inputs to out_*.
- out_ready→out_valid has no combinational dependency. out_valid falls the cycle after the last pop.
- Outputs hold stable while out_valid & !out_ready.
- state updates on the same edge as the triggering push, drop or abort.
- done is registered, asserted in the cycle state first reads IDLE.

## Test plan
- Trigger and stop: arm with start_pc=0x8000_0010, stop_count=3; commits at PCs 0x…08, 0x…0C, 0x…10, 0x…14, 0x…18, 0x…1C with out_ready=1 → exactly 0x…10, 0x…14, 0x…18 emitted. captured_count=3, state returns to IDLE, one done pulse.
- Overflow: DEPTH=8, stop_count=0, out_ready=0, 11 back-to-back events → captured=8, dropped=3. After out_ready=1 and 8 pops, the next pushed record has gap=1 and the following one has gap=0.
- Full plus simultaneous pop: FIFO full, out_ready=1 and an event in the same cycle → push accepted, dropped_count unchanged, FIFO stays full.
- Trap record: exception=1 with commit=0 at the trigger PC → captured with out_flags.exception=1. Record with rd_wenx=0 → out_rd_waddr=0, out_rd_wdata=0.
- Abort races: abort and trigger event in the same cycle while ARMED → IDLE, nothing captured, no done. Abort during CAPTURE with 2 records queued → DRAIN, 2 records emitted, then done.
- Reset: assert reset_n=0 mid-DRAIN with 5 records queued → out_valid=0 and all status fields read 0 immediately (asynchronous); arming is accepted after release.
